// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the serial floating-point adder.
//   - Default field widths of the packed format {sign, exp, mantissa}.
//   - FP_WIDTH, SUM_WIDTH (carry + hidden + fraction) and EXP_MAX (all-ones exponent).
//   - fp_seq_state_t: sequencer states.
//   - Field-extraction helpers for a packed operand of the default format.
package fp_pkg;

  localparam int FP_EXP_WIDTH      = 8;
  localparam int FP_MANTISSA_WIDTH = 23;
  localparam int FP_WIDTH          = 1 + FP_EXP_WIDTH + FP_MANTISSA_WIDTH;
  localparam int SUM_WIDTH         = FP_MANTISSA_WIDTH + 2;
  localparam logic [FP_EXP_WIDTH-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } fp_seq_state_t;

  function automatic logic fp_sign(input logic [FP_WIDTH-1:0] v);
    return v[FP_WIDTH-1];
  endfunction

  function automatic logic [FP_EXP_WIDTH-1:0] fp_exp(input logic [FP_WIDTH-1:0] v);
    return v[FP_WIDTH-2 -: FP_EXP_WIDTH];
  endfunction

  function automatic logic [FP_MANTISSA_WIDTH-1:0] fp_man(input logic [FP_WIDTH-1:0] v);
    return v[FP_MANTISSA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fp_norm_step.sv
// fp_norm_step: one combinational normalization step of the serial adder.
//   sum_i       sum {carry, hidden, fraction}
//   exp_i       exponent, one bit wider than the field so +1/-1 cannot wrap
//   sum_o/exp_o values after this step
//   done_o      normalization finished (zero, hidden bit set, overflow or underflow)
//   overflow_o  exponent reached all-ones after a carry shift
//   underflow_o exponent reached zero after a left shift
// On overflow/underflow sum_o is forced to zero so the packer emits no stray fraction.
module fp_norm_step #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [MANTISSA_WIDTH+1:0] sum_i,
  input  logic [EXP_WIDTH:0]        exp_i,
  output logic [MANTISSA_WIDTH+1:0] sum_o,
  output logic [EXP_WIDTH:0]        exp_o,
  output logic                      done_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam logic [EXP_WIDTH:0] EXP_ALL_ONES = {1'b0, {EXP_WIDTH{1'b1}}};

  always_comb begin
    sum_o       = sum_i;
    exp_o       = exp_i;
    done_o      = 1'b0;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    if (sum_i == '0) begin
      done_o = 1'b1;
      exp_o  = '0;
    end else if (sum_i[MANTISSA_WIDTH+1]) begin
      sum_o = sum_i >> 1;
      exp_o = exp_i + 1'b1;
      if (exp_o >= EXP_ALL_ONES) begin
        overflow_o = 1'b1;
        done_o     = 1'b1;
        sum_o      = '0;
        exp_o      = EXP_ALL_ONES;
      end
    end else if (sum_i[MANTISSA_WIDTH]) begin
      done_o = 1'b1;
    end else begin
      sum_o = sum_i << 1;
      exp_o = exp_i - 1'b1;
      if (exp_o == '0) begin
        underflow_o = 1'b1;
        done_o      = 1'b1;
        sum_o       = '0;
      end
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle floating-point adder, one shift per cycle.
//   clk_in        clock, rising edge
//   reset_in      synchronous active-high reset (aborts any operation, no done)
//   start_in      request, sampled only in IDLE
//   a_in, b_in    packed operands {sign, exp, mantissa}; exp 0 means zero
//   busy_out      high in every state except IDLE
//   done_out      one-cycle pulse when result_out/flags are updated
//   result_out    packed sum, held until the next done
//   overflow_out  result saturated to infinity (cleared on start accept)
//   underflow_out result flushed to zero (cleared on start accept)
// Flow: IDLE(load) -> ALIGN (right-shift smaller operand) -> ADD -> NORM -> DONE.
module fp_add_sequencer
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH      = FP_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH
) (
  input  logic                                clk_in,
  input  logic                                reset_in,
  input  logic                                start_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   b_in,
  output logic                                busy_out,
  output logic                                done_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   result_out,
  output logic                                overflow_out,
  output logic                                underflow_out
);

  localparam int W   = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int SW  = MANTISSA_WIDTH + 2;
  localparam int EW1 = EXP_WIDTH + 1;
  // Beyond this distance the smaller operand would shift out entirely.
  localparam logic [EXP_WIDTH:0] DIFF_LIMIT = EW1'(MANTISSA_WIDTH + 1);

  function automatic logic [W-1:0] saturate_inf(input logic s);
    return {s, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
  endfunction

  // A cleared hidden bit after normalization means zero or flushed underflow.
  function automatic logic [W-1:0] pack_result(input logic s,
                                               input logic [EXP_WIDTH-1:0] e,
                                               input logic [MANTISSA_WIDTH:0] m);
    if (!m[MANTISSA_WIDTH]) return '0;
    return {s, e, m[MANTISSA_WIDTH-1:0]};
  endfunction

  fp_seq_state_t state_q, state_d;

  logic                    done_q, done_d;
  logic [W-1:0]            result_q, result_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;

  logic                    sign_q, sign_d;
  logic                    eff_sub_q, eff_sub_d;
  logic [EXP_WIDTH:0]      exp_q, exp_d;
  logic [EXP_WIDTH:0]      diff_q, diff_d;
  logic [MANTISSA_WIDTH:0] m_l_q, m_l_d;
  logic [MANTISSA_WIDTH:0] m_s_q, m_s_d;
  logic [SW-1:0]           sum_q, sum_d;
  logic                    ovf_pend_q, ovf_pend_d;
  logic                    unf_pend_q, unf_pend_d;

  // Operand unpack and magnitude ordering
  logic                    a_sign, b_sign;
  logic [EXP_WIDTH-1:0]    a_exp, b_exp;
  logic [MANTISSA_WIDTH:0] a_sig, b_sig;
  logic                    b_larger;
  logic [EXP_WIDTH:0]      exp_l, exp_s, diff_full;

  assign a_sign    = a_in[W-1];
  assign b_sign    = b_in[W-1];
  assign a_exp     = a_in[W-2 -: EXP_WIDTH];
  assign b_exp     = b_in[W-2 -: EXP_WIDTH];
  assign a_sig     = (a_exp == '0) ? '0 : {1'b1, a_in[MANTISSA_WIDTH-1:0]};
  assign b_sig     = (b_exp == '0) ? '0 : {1'b1, b_in[MANTISSA_WIDTH-1:0]};
  assign b_larger  = {b_exp, b_sig} > {a_exp, a_sig};
  assign exp_l     = {1'b0, (b_larger ? b_exp : a_exp)};
  assign exp_s     = {1'b0, (b_larger ? a_exp : b_exp)};
  assign diff_full = exp_l - exp_s;

  logic [SW-1:0]      norm_sum;
  logic [EXP_WIDTH:0] norm_exp;
  logic               norm_done, norm_ovf, norm_unf;

  fp_norm_step #(
    .EXP_WIDTH      (EXP_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) u_norm_step (
    .sum_i       (sum_q),
    .exp_i       (exp_q),
    .sum_o       (norm_sum),
    .exp_o       (norm_exp),
    .done_o      (norm_done),
    .overflow_o  (norm_ovf),
    .underflow_o (norm_unf)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    sign_d      = sign_q;
    eff_sub_d   = eff_sub_q;
    exp_d       = exp_q;
    diff_d      = diff_q;
    m_l_d       = m_l_q;
    m_s_d       = m_s_q;
    sum_d       = sum_q;
    ovf_pend_d  = ovf_pend_q;
    unf_pend_d  = unf_pend_q;
    unique case (state_q)
      // Load: larger magnitude goes to L, distance precomputed
      IDLE: begin
        if (start_in) begin
          state_d     = ALIGN;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          sign_d      = b_larger ? b_sign : a_sign;
          eff_sub_d   = a_sign ^ b_sign;
          exp_d       = exp_l;
          m_l_d       = b_larger ? b_sig : a_sig;
          if (diff_full > DIFF_LIMIT) begin
            m_s_d  = '0;
            diff_d = '0;
          end else begin
            m_s_d  = b_larger ? a_sig : b_sig;
            diff_d = diff_full;
          end
        end
      end
      // Align: one truncating right shift of S per cycle
      ALIGN: begin
        if (diff_q == '0) begin
          state_d = ADD;
        end else begin
          m_s_d  = m_s_q >> 1;
          diff_d = diff_q - 1'b1;
        end
      end
      // Add: L >= S in magnitude, so the difference is never negative
      ADD: begin
        sum_d   = eff_sub_q ? ({1'b0, m_l_q} - {1'b0, m_s_q})
                            : ({1'b0, m_l_q} + {1'b0, m_s_q});
        state_d = NORM;
      end
      // Normalize: one step per cycle through the shared step logic
      NORM: begin
        sum_d = norm_sum;
        exp_d = norm_exp;
        if (norm_done) begin
          ovf_pend_d = norm_ovf;
          unf_pend_d = norm_unf;
          state_d    = DONE;
        end
      end
      // Done: publish result and flags with a single-cycle pulse
      DONE: begin
        result_d    = ovf_pend_q ? saturate_inf(sign_q)
                                 : pack_result(sign_q, exp_q[EXP_WIDTH-1:0],
                                               sum_q[MANTISSA_WIDTH:0]);
        overflow_d  = ovf_pend_q;
        underflow_d = unf_pend_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_in) begin
    sign_q     <= sign_d;
    eff_sub_q  <= eff_sub_d;
    exp_q      <= exp_d;
    diff_q     <= diff_d;
    m_l_q      <= m_l_d;
    m_s_q      <= m_s_d;
    sum_q      <= sum_d;
    ovf_pend_q <= ovf_pend_d;
    unf_pend_q <= unf_pend_d;
  end

  assign busy_out      = (state_q != IDLE);
  assign done_out      = done_q;
  assign result_out    = result_q;
  assign overflow_out  = overflow_q;
  assign underflow_out = underflow_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
module tb_fp_add_sequencer;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic start_in = 1'b0;
  logic [FP_WIDTH-1:0] a_in = '0;
  logic [FP_WIDTH-1:0] b_in = '0;
  logic busy_out, done_out, overflow_out, underflow_out;
  logic [FP_WIDTH-1:0] result_out;

  fp_add_sequencer dut (
    .clk_in        (clk),
    .reset_in      (reset_in),
    .start_in      (start_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .result_out    (result_out),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          acc;
    int          lat;
    logic [31:0] res;
    bit          ov;
    bit          un;
  } exp_t;

  exp_t expq[$];
  logic [31:0] last_res = '0;
  bit last_ov = 0;
  bit last_un = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: real-number style add on integer significands, counting cycles per phase.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output bit ov, output bit un,
                                output int lat);
    int ea, eb, ma, mb, el, es, ml, ms, diff, sum, e, steps;
    bit sl, sub;
    ea = int'(fp_exp(a));
    eb = int'(fp_exp(b));
    ma = (ea == 0) ? 0 : (int'(fp_man(a)) + (1 << FP_MANTISSA_WIDTH));
    mb = (eb == 0) ? 0 : (int'(fp_man(b)) + (1 << FP_MANTISSA_WIDTH));
    sub = fp_sign(a) != fp_sign(b);
    if (eb > ea || (eb == ea && mb > ma)) begin
      el = eb; ml = mb; es = ea; ms = ma; sl = fp_sign(b);
    end else begin
      el = ea; ml = ma; es = eb; ms = mb; sl = fp_sign(a);
    end
    diff = el - es;
    if (diff > FP_MANTISSA_WIDTH + 1) begin
      ms = 0;
      diff = 0;
    end
    ms = ms / (1 << diff);
    sum = sub ? (ml - ms) : (ml + ms);
    e = el;
    ov = 0;
    un = 0;
    steps = 0;
    res = '0;
    if (sum == 0) begin
      steps = 1;
    end else if (sum >= (1 << (SUM_WIDTH - 1))) begin
      sum = sum / 2;
      e = e + 1;
      steps = 1;
      if (e >= int'(EXP_MAX)) begin
        ov = 1;
        res = {sl, EXP_MAX, 23'd0};
      end else begin
        steps = 2;
        res = {sl, 8'(e), 23'(sum)};
      end
    end else begin
      while (sum < (1 << FP_MANTISSA_WIDTH) && !un) begin
        sum = sum * 2;
        e = e - 1;
        steps++;
        if (e == 0) un = 1;
      end
      if (!un) begin
        steps++;
        res = {sl, 8'(e), 23'(sum)};
      end
    end
    lat = 3 + diff + steps;
  endfunction

  // Every-cycle compare, sampled 1ns after the active edge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    bit busy_e, done_e;
    #1;
    busy_e = 0;
    done_e = 0;
    if (expq.size() > 0) begin
      if (cyc >= expq[0].acc && cyc < expq[0].acc + expq[0].lat) busy_e = 1;
      if (cyc == expq[0].acc + expq[0].lat) done_e = 1;
    end
    if (done_e) begin
      last_res = expq[0].res;
      last_ov  = expq[0].ov;
      last_un  = expq[0].un;
      void'(expq.pop_front());
    end else if (busy_e) begin
      last_ov = 0;
      last_un = 0;
    end
    chk("busy_out", 32'(busy_out), 32'(busy_e));
    chk("done_out", 32'(done_out), 32'(done_e));
    chk("result_out", result_out, last_res);
    chk("overflow_out", 32'(overflow_out), 32'(last_ov));
    chk("underflow_out", 32'(underflow_out), 32'(last_un));
  end

  // Called at a negedge with the DUT idle; returns at the negedge where done_out is high.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit hold);
    exp_t x;
    int n;
    model(a, b, x.res, x.ov, x.un, x.lat);
    x.acc = cyc + 1;
    expq.push_back(x);
    a_in = a;
    b_in = b;
    start_in = 1'b1;
    @(negedge clk);
    if (!hold) start_in = 1'b0;
    n = 0;
    while (!done_out && n < 100) begin
      if (hold) begin
        a_in = $urandom;
        b_in = $urandom;
      end
      @(negedge clk);
      n++;
    end
    start_in = 1'b0;
    if (!done_out) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done_out for %h + %h, expected after %0d cycles", a, b, x.lat);
      expq.delete();
    end
  endtask

  function automatic logic [31:0] rand_op(input int lo, input int hi);
    return {1'($urandom_range(0, 1)), 8'($urandom_range(lo, hi)), 23'($urandom)};
  endfunction

  task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res_req, input bit ov_req, input bit un_req,
                     input int lat_req);
    logic [31:0] r;
    bit ov, un;
    int lat;
    model(a, b, r, ov, un, lat);
    chk({nm, "_res"}, r, res_req);
    chk({nm, "_flags"}, {30'd0, ov, un}, {30'd0, ov_req, un_req});
    if (lat_req >= 0) chk({nm, "_lat"}, 32'(lat), 32'(lat_req));
  endtask

  initial begin
    logic [31:0] a, b;
    #500000;
    $display("FAIL global_timeout: bench did not finish, got time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    bit hold;
    // Hand-computed expectations pinning the reference model.
    pin("pin_1p1",   32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 5);
    pin("pin_1p5",   32'h3FC00000, 32'h3E800000, 32'h3FE00000, 0, 0, 6);
    pin("pin_1m075", 32'h3F800000, 32'hBF400000, 32'h3E800000, 0, 0, 7);
    pin("pin_cancel",32'h3F800000, 32'hBF800000, 32'h00000000, 0, 0, -1);
    pin("pin_ovf",   32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, -1);
    pin("pin_unf",   32'h00C00000, 32'h80800000, 32'h00000000, 0, 1, -1);

    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);

    issue(32'h3F800000, 32'h3F800000, 0);
    issue(32'h3FC00000, 32'h3E800000, 0);
    issue(32'h3F800000, 32'hBF400000, 0);

    // Abort mid-ALIGN: outputs cleared, no done for the aborted op.
    @(negedge clk);
    begin
      exp_t x;
      model(32'h45000000, 32'h3F800000, x.res, x.ov, x.un, x.lat);
      x.acc = cyc + 1;
      expq.push_back(x);
    end
    a_in = 32'h45000000;
    b_in = 32'h3F800000;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_in = 1'b1;
    expq.delete();
    last_res = '0;
    last_ov = 0;
    last_un = 0;
    @(negedge clk);
    reset_in = 1'b0;
    repeat (40) @(negedge clk);

    issue(32'h3F800000, 32'hBF800000, 0);
    issue(32'h7F000000, 32'h7F000000, 0);
    issue(32'h3FC00000, 32'h3E800000, 1);
    issue(32'h00C00000, 32'h80800000, 0);
    issue(32'h3F800000, 32'h45000000, 0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: begin a = rand_op(0, 254); b = rand_op(0, 254); end
        1: begin a = rand_op(1, 254); b = a ^ 32'h80000000 ^ 32'($urandom_range(0, 255)); end
        2: begin a = rand_op(248, 254); b = rand_op(248, 254); end
        3: begin a = rand_op(1, 254); b = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)}; end
        default: begin a = rand_op(1, 3); b = a ^ 32'h80000000 ^ 32'($urandom_range(0, 4095)); end
      endcase
      hold = ($urandom_range(0, 4) == 0);
      issue(a, b, hold);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
